// File: rtl/key_scan_debounce_pkg.sv
// Shared sizes, column-state encoding and key/column helpers for the key scanner.
package key_scan_pkg;

    localparam int NUM_COLS = 3;
    localparam int NUM_ROWS = 3;
    localparam int NUM_KEYS = NUM_COLS * NUM_ROWS;

    typedef enum logic [1:0] {
        COL0 = 2'd0,
        COL1 = 2'd1,
        COL2 = 2'd2
    } col_state_t;

    function automatic int key_index(input int col, input int row);
        return col * NUM_ROWS + row;
    endfunction

    // Active-low column drive: exactly one zero for the selected column.
    function automatic logic [NUM_COLS-1:0] col_drive(input col_state_t c);
        return ~(NUM_COLS'(1) << c);
    endfunction

endpackage

// File: rtl/key_scan_debounce_if.sv
// Matrix pins plus debounced key outputs; master is the scanner, slave the board/consumer side.
interface key_scan_debounce_if;
    import key_scan_pkg::*;

    logic [NUM_ROWS-1:0] SW_INPUT;
    logic [NUM_COLS-1:0] SW_COMMON;
    logic [NUM_KEYS-1:0] key_level;
    logic [NUM_KEYS-1:0] key_press;
    logic [NUM_KEYS-1:0] key_release;
    logic [1:0]          scan_col;

    modport master (
        input  SW_INPUT,
        output SW_COMMON, key_level, key_press, key_release, scan_col
    );

    modport slave (
        output SW_INPUT,
        input  SW_COMMON, key_level, key_press, key_release, scan_col
    );

endinterface

// File: rtl/key_scan_debounce_cell.sv
// Per-key debouncer: stable state changes after DEBOUNCE_CNT consecutive disagreeing samples.
// Press/release pulses are registered and last one cycle.
module key_debounce_cell #(
    parameter int DEBOUNCE_CNT = 3
) (
    input  logic CLK,
    input  logic RESET,
    input  logic sample_en,
    input  logic raw,
    output logic level,
    output logic press,
    output logic release_pulse
);

    localparam logic [3:0] CNT_LAST = 4'(DEBOUNCE_CNT);

    logic       stable;
    logic [3:0] cnt;
    logic       hit;

    assign hit   = (cnt + 4'd1) == CNT_LAST;
    assign level = stable;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            stable        <= 1'b0;
            cnt           <= 4'd0;
            press         <= 1'b0;
            release_pulse <= 1'b0;
        end else begin
            press         <= 1'b0;
            release_pulse <= 1'b0;
            if (sample_en) begin
                if (raw == stable) begin
                    cnt <= 4'd0;
                end else if (hit) begin
                    stable        <= raw;
                    cnt           <= 4'd0;
                    press         <= raw;
                    release_pulse <= ~raw;
                end else begin
                    cnt <= cnt + 4'd1;
                end
            end
        end
    end

endmodule

// File: rtl/key_scan_debounce.sv
// 3x3 matrix scanner: rotates column drive every SCAN_DIV cycles, samples synchronized rows
// at the end of each slot and debounces every key independently.
module key_scan_debounce
    import key_scan_pkg::*;
#(
    parameter int SCAN_DIV     = 5000,
    parameter int DEBOUNCE_CNT = 3
) (
    input  logic                CLK,
    input  logic                RESET,
    key_scan_debounce_if.master bus
);

    localparam int               DIV_W    = $clog2(SCAN_DIV);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);

    col_state_t          state, state_next;
    logic [1:0]          state_idx;
    logic [DIV_W-1:0]    div_cnt;
    logic                strobe;
    logic [NUM_ROWS-1:0] sync_a, sync_b;
    logic [NUM_COLS-1:0] sw_common;
    logic [1:0]          scan_col;
    logic [NUM_KEYS-1:0] sample_en;
    logic [NUM_KEYS-1:0] level, press, release_pulse;

    assign strobe    = (div_cnt == DIV_LAST);
    assign state_idx = state;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state <= COL0;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        if (strobe) begin
            case (state)
                COL0:    state_next = COL1;
                COL1:    state_next = COL2;
                COL2:    state_next = COL0;
                default: state_next = COL0;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            div_cnt <= '0;
        end else if (strobe) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + DIV_W'(1);
        end
    end

    // Column drive is registered from the current state so it moves the cycle after the wrap.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            sw_common <= '1;
            scan_col  <= 2'd0;
        end else begin
            sw_common <= col_drive(state);
            scan_col  <= state_idx;
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            sync_a <= '1;
            sync_b <= '1;
        end else begin
            sync_a <= bus.SW_INPUT;
            sync_b <= sync_a;
        end
    end

    for (genvar c = 0; c < NUM_COLS; c++) begin : g_col
        for (genvar r = 0; r < NUM_ROWS; r++) begin : g_row
            localparam int K = key_index(c, r);

            assign sample_en[K] = strobe && (state_idx == 2'(c));

            key_debounce_cell #(
                .DEBOUNCE_CNT (DEBOUNCE_CNT)
            ) u_cell (
                .CLK           (CLK),
                .RESET         (RESET),
                .sample_en     (sample_en[K]),
                .raw           (~sync_b[r]),
                .level         (level[K]),
                .press         (press[K]),
                .release_pulse (release_pulse[K])
            );
        end
    end

    assign bus.SW_COMMON   = sw_common;
    assign bus.scan_col    = scan_col;
    assign bus.key_level   = level;
    assign bus.key_press   = press;
    assign bus.key_release = release_pulse;

endmodule

// File: tb/tb_key_scan_debounce.sv
// Directed bench for key_scan_debounce with SCAN_DIV=8, DEBOUNCE_CNT=3 (frame = 24 cycles).
module tb_key_scan_debounce;

    localparam int SCAN_DIV = 8;
    localparam int FRAME    = 3 * SCAN_DIV;

    typedef struct {
        logic [8:0]  mask;
        logic [11:0] pattern;     // bit f = keys in mask pressed during frame f
        int          nframes;
        int          press_frame; // -1: no press pulse expected
        int          rel_frame;   // -1: no release pulse expected
        logic        exp_level;
    } rec_t;

    logic CLK = 1'b0;
    logic RESET = 1'b1;
    logic [8:0] pressed = '0;
    logic [8:0] async_pressed = '0;
    logic       async_on = 1'b0;
    logic [8:0] cur_pressed;
    logic [2:0] sw_in;
    int cyc = 0;
    int tests = 0;
    int failed = 0;

    key_scan_debounce_if bus();

    key_scan_debounce #(
        .SCAN_DIV     (SCAN_DIV),
        .DEBOUNCE_CNT (3)
    ) dut (
        .CLK   (CLK),
        .RESET (RESET),
        .bus   (bus)
    );

    always #5 CLK = ~CLK;

    // Physical matrix: a pressed key pulls its row low while its column is driven.
    assign cur_pressed = async_on ? async_pressed : pressed;
    always_comb begin
        sw_in = 3'b111;
        for (int c = 0; c < 3; c++)
            for (int r = 0; r < 3; r++)
                if (!bus.SW_COMMON[c] && cur_pressed[c*3+r]) sw_in[r] = 1'b0;
    end
    assign bus.SW_INPUT = sw_in;

    initial begin
        forever begin
            if ($urandom_range(0, 3) == 0) @(posedge CLK);
            else #($urandom_range(1, 13));
            async_pressed = 9'($urandom);
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cyc %0d",
                     name, act, act, exp, exp, cyc);
        end
    endtask

    task automatic do_reset(input int n);
        @(posedge CLK);
        #1 RESET = 1'b1;
        for (int i = 0; i < n; i++) begin
            @(posedge CLK);
            @(negedge CLK);
            check("reset_sw_common", 32'(bus.SW_COMMON), 32'h7);
            check("reset_key_outs", 32'({bus.key_level, bus.key_press, bus.key_release}), 32'h0);
        end
        RESET = 1'b0;
        cyc = -1;
    endtask

    task automatic run_rec(input rec_t r, input int idx);
        int pc[9], rc[9], pcyc[9], rcyc[9];
        int other, both;
        other = 0;
        both  = 0;
        for (int k = 0; k < 9; k++) begin
            pc[k] = 0; rc[k] = 0; pcyc[k] = -1; rcyc[k] = -1;
        end
        pressed = '0;
        do_reset(2);
        for (int n = 0; n < r.nframes * FRAME; n++) begin
            @(posedge CLK);
            cyc++;
            #1 pressed = r.pattern[cyc / FRAME] ? r.mask : 9'h0;
            @(negedge CLK);
            if ((bus.key_press & bus.key_release) != 9'h0) both++;
            for (int k = 0; k < 9; k++) begin
                if (bus.key_press[k]) begin
                    if (r.mask[k]) begin
                        pc[k]++;
                        if (pc[k] == 1) pcyc[k] = cyc;
                    end else other++;
                end
                if (bus.key_release[k]) begin
                    if (r.mask[k]) begin
                        rc[k]++;
                        if (rc[k] == 1) rcyc[k] = cyc;
                    end else other++;
                end
            end
        end
        for (int k = 0; k < 9; k++) begin
            if (r.mask[k]) begin
                check($sformatf("rec%0d_k%0d_press_count", idx, k), 32'(pc[k]),
                      (r.press_frame >= 0) ? 32'd1 : 32'd0);
                check($sformatf("rec%0d_k%0d_release_count", idx, k), 32'(rc[k]),
                      (r.rel_frame >= 0) ? 32'd1 : 32'd0);
                if (r.press_frame >= 0)
                    check($sformatf("rec%0d_k%0d_press_cyc", idx, k), 32'(pcyc[k]),
                          32'(r.press_frame * FRAME + (k / 3) * SCAN_DIV + SCAN_DIV - 1));
                if (r.rel_frame >= 0)
                    check($sformatf("rec%0d_k%0d_release_cyc", idx, k), 32'(rcyc[k]),
                          32'(r.rel_frame * FRAME + (k / 3) * SCAN_DIV + SCAN_DIV - 1));
            end
        end
        check($sformatf("rec%0d_level", idx), 32'(bus.key_level),
              r.exp_level ? 32'(r.mask) : 32'h0);
        check($sformatf("rec%0d_other_pulses", idx), 32'(other), 32'd0);
        check($sformatf("rec%0d_both_pulses", idx), 32'(both), 32'd0);
    endtask

    initial begin
        rec_t recs[8];
        int   cnt, pcy, other, viol, xs;
        logic [2:0] exp_common;

        recs[0] = '{9'h010, 12'h01F, 10,  2,  7, 1'b0}; // key 4 clean press/release
        recs[1] = '{9'h001, 12'h07B,  7,  5, -1, 1'b1}; // key 0 bounce then hold
        recs[2] = '{9'h100, 12'h002,  5, -1, -1, 1'b0}; // key 8 one-frame glitch
        recs[3] = '{9'h004, 12'h003,  5, -1, -1, 1'b0}; // key 2 two-frame glitch
        recs[4] = '{9'h080, 12'h0EF,  8,  2, -1, 1'b1}; // key 7 release glitch rejected
        recs[5] = '{9'h020, 12'h007,  7,  2,  5, 1'b0}; // key 5 press of exactly 3 frames
        recs[6] = '{9'h111, 12'h00F,  4,  2, -1, 1'b1}; // keys 0,4,8 together
        recs[7] = '{9'h002, 12'hFFE,  6,  3, -1, 1'b1}; // key 1 pressed from frame 1

        // Reset and scan rotation
        do_reset(3);
        for (int n = 0; n < 2 * FRAME; n++) begin
            @(posedge CLK);
            cyc++;
            @(negedge CLK);
            exp_common = ~(3'b001 << ((cyc / SCAN_DIV) % 3));
            check("rot_sw_common", 32'(bus.SW_COMMON), 32'(exp_common));
            check("rot_scan_col", 32'(bus.scan_col), 32'((cyc / SCAN_DIV) % 3));
        end

        for (int i = 0; i < 8; i++) run_rec(recs[i], i);

        // Reset after two agreeing samples of key 2, key held through reset
        pressed = '0;
        do_reset(2);
        other = 0;
        for (int n = 0; n < 40; n++) begin
            @(posedge CLK);
            cyc++;
            #1 pressed = 9'h004;
            @(negedge CLK);
            if ((bus.key_press | bus.key_release) != 9'h0) other++;
        end
        check("midreset_pre_pulses", 32'(other), 32'd0);
        do_reset(3);
        cnt = 0;
        pcy = -1;
        other = 0;
        for (int n = 0; n < 3 * FRAME; n++) begin
            @(posedge CLK);
            cyc++;
            @(negedge CLK);
            if (bus.key_press[2]) begin
                cnt++;
                if (cnt == 1) pcy = cyc;
            end
            if ((bus.key_press & ~9'h004) != 9'h0 || bus.key_release != 9'h0) other++;
        end
        check("midreset_press_count", 32'(cnt), 32'd1);
        check("midreset_press_cyc", 32'(pcy), 32'(2 * FRAME + SCAN_DIV - 1));
        check("midreset_other", 32'(other), 32'd0);
        check("midreset_level", 32'(bus.key_level), 32'h004);

        // Asynchronous input toggling
        pressed = '0;
        do_reset(2);
        async_on = 1'b1;
        viol = 0;
        xs = 0;
        for (int n = 0; n < 12 * FRAME; n++) begin
            @(posedge CLK);
            cyc++;
            @(negedge CLK);
            if ($isunknown({bus.SW_COMMON, bus.scan_col, bus.key_level,
                            bus.key_press, bus.key_release})) xs++;
            for (int k = 0; k < 9; k++)
                if ((bus.key_press[k] || bus.key_release[k]) && (k / 3) != ((cyc / SCAN_DIV) % 3))
                    viol++;
            if ((bus.key_press & bus.key_release) != 9'h0) viol++;
        end
        async_on = 1'b0;
        check("async_unknowns", 32'(xs), 32'd0);
        check("async_wrong_column_pulses", 32'(viol), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
